// File: rtl/pkt_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : pkt_packetizer
// Purpose  : Wraps payload words in {dest, src, seq} headers and queues the
//            packets in an output FIFO. Define PKT_PARITY_EN to prepend an
//            even-parity MSB to every packet.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_packetizer #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int SEQ_W    = 4,
  parameter int SRC_ID   = 0,
  parameter int NUM_DEST = 4,
  parameter int DEPTH    = 4,
`ifdef PKT_PARITY_EN
  localparam int PKT_W   = DATA_W + 2*ADDR_W + SEQ_W + 1
`else
  localparam int PKT_W   = DATA_W + 2*ADDR_W + SEQ_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dest_mode,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              pkt_out_valid,
  input  logic              pkt_out_ready,
  output logic [PKT_W-1:0]  pkt_out,
  output logic              err_dest,
  output logic [15:0]       pkt_count
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_BODY_W = DATA_W + 2*ADDR_W + SEQ_W;

  logic [PKT_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [ADDR_W-1:0]  r_rr;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_err;
  logic [15:0]        r_pkt_count;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_dest;
  logic [c_BODY_W-1:0] w_body;
  logic [PKT_W-1:0]   w_pkt;

  assign w_full   = (r_count == (c_PTR_W+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = data_in_valid && !w_full;
  // Extra MSB keeps the compare correct when NUM_DEST == 2**ADDR_W
  assign w_drop   = dest_mode && ({1'b0, dest_in} >= (ADDR_W+1)'(NUM_DEST));
  assign w_push   = w_accept && !w_drop;
  assign w_pop    = !w_empty && pkt_out_ready;
  assign w_dest   = dest_mode ? dest_in : r_rr;
  assign w_body   = {w_dest, ADDR_W'(SRC_ID), r_seq, data_in};

`ifdef PKT_PARITY_EN
  assign w_pkt = {^w_body, w_body};
`else
  assign w_pkt = w_body;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rr        <= '0;
      r_seq       <= '0;
      r_err       <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_err <= w_accept && w_drop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        r_seq    <= r_seq + SEQ_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        if (r_pkt_count != 16'hFFFF)
          r_pkt_count <= r_pkt_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && !dest_mode)
        r_rr <= (r_rr == ADDR_W'(NUM_DEST-1)) ? '0 : r_rr + ADDR_W'(1);
    end
  end

  // Storage needs no reset: the empty mux below hides stale entries
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_pkt;
  end

  assign data_in_ready = !w_full;
  assign pkt_out_valid = !w_empty;
  assign pkt_out       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign err_dest      = r_err;
  assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_pkt_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_packetizer
// Purpose  : Directed self-checking bench for pkt_packetizer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_packetizer;

`ifdef PKT_PARITY_EN
  localparam int PW = 37;
  localparam logic [PW-1:0] c_FIRST = 37'h1000000001;
`else
  localparam int PW = 36;
  localparam logic [PW-1:0] c_FIRST = 36'h000000001;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [23:0]   data_in = '0;
  logic          dest_mode = 1'b0;
  logic [3:0]    dest_in = '0;
  logic          pkt_out_valid;
  logic          pkt_out_ready = 1'b0;
  logic [PW-1:0] pkt_out;
  logic          err_dest;
  logic [15:0]   pkt_count;

  int n_checks = 0;
  int n_errors = 0;
  int rr;
  int seq;

  pkt_packetizer dut (
    .clk           (clk),
    .reset         (reset),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_in       (data_in),
    .dest_mode     (dest_mode),
    .dest_in       (dest_in),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .pkt_out       (pkt_out),
    .err_dest      (err_dest),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input int d, input int s, input int dat);
    logic [35:0] b;
    b = {4'(d), 4'h0, 4'(s), 24'(dat)};
`ifdef PKT_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 64'(data_in_ready), 64'd1);
    check("rst_valid", 64'(pkt_out_valid), 64'd0);
    check("rst_pkt",   64'(pkt_out),       64'd0);
    check("rst_err",   64'(err_dest),      64'd0);
    check("rst_count", 64'(pkt_count),     64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Round-robin, downstream always ready
    pkt_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 24'(i);
      data_in_valid = 1'b1;
      tick();
      check("rr_valid", 64'(pkt_out_valid), 64'd1);
      check("rr_pkt",   64'(pkt_out), 64'(mk((i-1)%4, i-1, i)));
      if (i == 1) check("first_pkt", 64'(pkt_out), 64'(c_FIRST));
`ifdef PKT_PARITY_EN
      check("rr_parity", 64'(^pkt_out), 64'd0);
`endif
    end
    data_in_valid = 1'b0;
    tick();
    check("rr_empty", 64'(pkt_out_valid), 64'd0);
    check("rr_pkt0",  64'(pkt_out),       64'd0);
    check("rr_count", 64'(pkt_count),     64'd5);

    // Backpressure: fill FIFO (rr=1, seq=5)
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 24'(16 + i);
      data_in_valid = 1'b1;
      check("bp_ready", 64'(data_in_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    data_in_valid = 1'b0;
    check("bp_full_ready", 64'(data_in_ready), 64'd0);
    pkt_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("drain_valid", 64'(pkt_out_valid), 64'd1);
      check("drain_pkt", 64'(pkt_out), 64'(mk((1+j)%4, 5+j, 16+j)));
      tick();
      if (j == 0) check("drain_ready", 64'(data_in_ready), 64'd1);
    end
    check("drain_empty", 64'(pkt_out_valid), 64'd0);
    check("drain_count", 64'(pkt_count), 64'd9);

    // Bad destination drop (rr=1, seq=9)
    dest_mode = 1'b1;
    dest_in = 4'd7;
    data_in = 24'hABC;
    data_in_valid = 1'b1;
    tick();
    check("drop_err",   64'(err_dest),      64'd1);
    check("drop_valid", 64'(pkt_out_valid), 64'd0);
    dest_in = 4'd2;
    data_in = 24'h55;
    tick();
    check("drop_err_clr", 64'(err_dest), 64'd0);
    check("drop_next", 64'(pkt_out), 64'(mk(2, 9, 24'h55)));
    dest_mode = 1'b0;
    data_in = 24'h66;
    tick();
    check("rr_held", 64'(pkt_out), 64'(mk(1, 10, 24'h66)));
    data_in_valid = 1'b0;
    tick();
    check("drop_count", 64'(pkt_count), 64'd11);

    // Mid-stream asynchronous reset with 3 queued (rr=2, seq=11)
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 24'(8'h81 + i);
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
    check("q_head", 64'(pkt_out), 64'(mk(2, 11, 24'h81)));
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(pkt_out_valid), 64'd0);
    check("arst_pkt",   64'(pkt_out),       64'd0);
    check("arst_ready", 64'(data_in_ready), 64'd1);
    check("arst_count", 64'(pkt_count),     64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    pkt_out_ready = 1'b1;
    data_in = 24'h77;
    data_in_valid = 1'b1;
    tick();
    check("post_rst_pkt", 64'(pkt_out), 64'(mk(0, 0, 24'h77)));

    // Sustained streaming, covers seq wrap 15 -> 0
    rr = 1;
    seq = 1;
    for (int k = 0; k < 100; k++) begin
      data_in = 24'(24'h1000 + k);
      check("stream_ready", 64'(data_in_ready), 64'd1);
      tick();
      check("stream_valid", 64'(pkt_out_valid), 64'd1);
      check("stream_pkt", 64'(pkt_out), 64'(mk(rr, seq, 24'h1000 + k)));
`ifdef PKT_PARITY_EN
      check("stream_parity", 64'(^pkt_out), 64'd0);
`endif
      rr = (rr + 1) % 4;
      seq = (seq + 1) % 16;
    end
    data_in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(pkt_out_valid), 64'd0);
    check("stream_count", 64'(pkt_count), 64'd101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_packetizer.md
# pkt_packetizer

Clocked, parametrised successor to the 24-bit packet PE. It accepts raw data words on a valid/ready channel and wraps each one in a header: destination, source ID and sequence number. Destinations come either from a round-robin counter or from a per-word field. Finished packets are buffered in a FIFO and presented on an output valid/ready channel toward the router network.

## Interface
Parameters:
- DATA_W, 24, payload width
- ADDR_W, 4, destination/source address width
- SEQ_W, 4, sequence-number width
- SRC_ID, 0, this node's source address, ADDR_W bits
- NUM_DEST, 4, valid destinations 0..NUM_DEST-1; range 1 to 2^ADDR_W
- DEPTH, 4, output FIFO entries; power of two, at least 2
- PKT_W, derived, DATA_W+2*ADDR_W+SEQ_W, plus 1 with parity (default 36/37)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_in_valid  in  1  input word present
- data_in_ready  out  1  block can accept a word
- data_in  in  DATA_W  payload
- dest_mode  in  1  0 = round-robin destination, 1 = use dest_in
- dest_in  in  ADDR_W  destination when dest_mode=1
- pkt_out_valid  out  1  FIFO head valid
- pkt_out_ready  in  1  downstream accepts
- pkt_out  out  PKT_W  {[parity], dest, src, seq, data}, MSB first
- err_dest  out  1  one-cycle pulse: word dropped for bad destination
- pkt_count  out  16  packets delivered, saturating

## Operation
- Accept: data_in_valid && data_in_ready at a rising edge.
- Destination selection on accept:
  - dest_mode=0: dest = rr_ptr; rr_ptr then increments, wrapping NUM_DEST-1 -> 0.
  - dest_mode=1: dest = dest_in; rr_ptr unchanged.
- Drop rule: dest_mode=1 and dest_in >= NUM_DEST.
  - Word consumed, nothing pushed.
  - err_dest=1 for the following cycle.
  - seq unchanged.
- Valid accept:
  - Packet {dest, SRC_ID, seq, data_in} written into the FIFO.
  - seq increments mod 2^SEQ_W.
- Pop: pkt_out_valid && pkt_out_ready. FIFO read pointer advances; pkt_count increments, saturating at 16'hFFFF.
- FIFO pointers: ADDR-width pointers plus a count register.
  - full: count==DEPTH.
  - empty: count==0.
- data_in_ready = !full. A pop in the same cycle does not free the slot until the next cycle.
- Push and pop in the same cycle (not full, not empty): both happen; count unchanged.
- Reset, asynchronous and mid-operation: FIFO flushed, packets lost, no partial output. All outputs below return to their reset values immediately.

## Timing
- Reset values:
  - data_in_ready=1, pkt_out_valid=0, pkt_out=0, err_dest=0, pkt_count=0.
  - Internal: seq=0, rr_ptr=0, count=0.
- Latency: word accepted at edge N; packet visible at pkt_out with pkt_out_valid=1 after edge N, when the FIFO was empty. One cycle.
- pkt_out is driven from the FIFO head register and is stable while pkt_out_valid=1 && !pkt_out_ready.
- pkt_out is 0 when the FIFO is empty.
- Throughput: one packet per cycle sustained when pkt_out_ready is held high.
- data_in_ready is registered-state-derived only; no combinational path from pkt_out_ready.

## Configuration
- PKT_PARITY_EN defined:
  - PKT_W gains one MSB holding even parity over the remaining PKT_W-1 bits, so XOR of all PKT_W bits = 0.
  - Computed at FIFO write.
- Not defined: no parity bit; PKT_W = DATA_W+2*ADDR_W+SEQ_W.

## Test plan
- Reset, then words 0x000001, 0x000002, 0x000003, 0x000004, 0x000005 with dest_mode=0 and pkt_out_ready=1:
  - dests 0,1,2,3,0; seq 0..4; src 0.
  - First pkt_out = 36'h000000001, one cycle after accept.
  - pkt_count=5.
- pkt_out_ready=0, push 5 words: 4 accepted, data_in_ready=0 after the 4th. Then ready=1: packets drain in order, data_in_ready returns to 1.
- dest_mode=1, dest_in=7 with NUM_DEST=4: word consumed, err_dest pulses one cycle, no packet, next valid word carries the unchanged seq.
- Assert reset mid-stream with 3 packets queued: pkt_out_valid=0 immediately; after release, next packet has seq=0, dest=0.
- 17 accepts: seq wraps 15 -> 0.
- Hold data_in_valid and pkt_out_ready high for 100 cycles: one packet per cycle, pkt_out_valid stays high.
- With PKT_PARITY_EN, data 0x000001, dest 0: parity bit = 1, and XOR of all bits of every output packet = 0.
